// File: rtl/ws_inst_sequencer_pkg.sv
// ws_seq_pkg: shared types and constants for the weight-stationary instruction
// sequencer and its instruction packer.
//   - state_e        : sequencer FSM states
//   - BIT_* / *_LSB  : bit positions inside the 35-bit core instruction word
//   - inst_fields_t  : unpacked view of one instruction word
//   - INST_DEFAULT   : idle instruction (both SRAMs deselected, write-disabled)
package ws_seq_pkg;

  localparam int ADDR_BW = 11;
  localparam int INST_W  = 35;
  localparam int CNT_W   = 8;

  localparam int BIT_MODE     = 34;
  localparam int BIT_ACC      = 33;
  localparam int BIT_CEN_PMEM = 32;
  localparam int BIT_WEN_PMEM = 31;
  localparam int A_PMEM_LSB   = 20;
  localparam int BIT_CEN_XMEM = 19;
  localparam int BIT_WEN_XMEM = 18;
  localparam int A_XMEM_LSB   = 7;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_IFIFO_WR = 5;
  localparam int BIT_IFIFO_RD = 4;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_EXECUTE  = 1;
  localparam int BIT_LOAD     = 0;

  typedef enum logic [3:0] {
    IDLE, WL0, WPE, WDR, AL0, EXE, EDR, ORD, NXT, DONE
  } state_e;

  typedef struct packed {
    logic               mode;
    logic               acc;
    logic               cen_pmem;
    logic               wen_pmem;
    logic [ADDR_BW-1:0] a_pmem;
    logic               cen_xmem;
    logic               wen_xmem;
    logic [ADDR_BW-1:0] a_xmem;
    logic               ofifo_rd;
    logic               ififo_wr;
    logic               ififo_rd;
    logic               l0_rd;
    logic               l0_wr;
    logic               execute;
    logic               load;
  } inst_fields_t;

  localparam inst_fields_t INST_FIELDS_DEFAULT = '{
    mode: 1'b0, acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1, a_pmem: '0,
    cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: '0, ofifo_rd: 1'b0,
    ififo_wr: 1'b0, ififo_rd: 1'b0, l0_rd: 1'b0, l0_wr: 1'b0,
    execute: 1'b0, load: 1'b0
  };

  localparam logic [INST_W-1:0] INST_DEFAULT =
      (INST_W'(1) << BIT_CEN_PMEM) | (INST_W'(1) << BIT_WEN_PMEM) |
      (INST_W'(1) << BIT_CEN_XMEM) | (INST_W'(1) << BIT_WEN_XMEM);

endpackage

// File: rtl/ws_inst_sequencer_if.sv
// ws_inst_sequencer_if: control/instruction bundle between the sequencer
// (master) and the host/core side (slave).
//   start       host -> seq  one-cycle start pulse
//   ofifo_valid core -> seq  OFIFO holds a psum row
//   busy        seq  -> host pass in progress
//   done        seq  -> host one-cycle completion pulse
//   kij_idx     seq  -> host current kernel position
//   inst        seq  -> core 35-bit instruction word
interface ws_inst_sequencer_if;
  logic                          start;
  logic                          ofifo_valid;
  logic                          busy;
  logic                          done;
  logic [3:0]                    kij_idx;
  logic [ws_seq_pkg::INST_W-1:0] inst;

  modport master (input start, input ofifo_valid,
                  output busy, output done, output kij_idx, output inst);
  modport slave  (output start, output ofifo_valid,
                  input busy, input done, input kij_idx, input inst);
endinterface

// File: rtl/ws_inst_sequencer_pack.sv
// ws_inst_pack: purely combinational packer from named instruction fields to
// the 35-bit core instruction word. Shared with other sequencer flavours.
//   fields : inst_fields_t view of the instruction
//   inst   : packed instruction word
module ws_inst_pack
  import ws_seq_pkg::*;
(
  input  inst_fields_t      fields,
  output logic [INST_W-1:0] inst
);
  always_comb begin
    inst                              = '0;
    inst[BIT_MODE]                    = fields.mode;
    inst[BIT_ACC]                     = fields.acc;
    inst[BIT_CEN_PMEM]                = fields.cen_pmem;
    inst[BIT_WEN_PMEM]                = fields.wen_pmem;
    inst[A_PMEM_LSB +: ADDR_BW]       = fields.a_pmem;
    inst[BIT_CEN_XMEM]                = fields.cen_xmem;
    inst[BIT_WEN_XMEM]                = fields.wen_xmem;
    inst[A_XMEM_LSB +: ADDR_BW]       = fields.a_xmem;
    inst[BIT_OFIFO_RD]                = fields.ofifo_rd;
    inst[BIT_IFIFO_WR]                = fields.ififo_wr;
    inst[BIT_IFIFO_RD]                = fields.ififo_rd;
    inst[BIT_L0_RD]                   = fields.l0_rd;
    inst[BIT_L0_WR]                   = fields.l0_wr;
    inst[BIT_EXECUTE]                 = fields.execute;
    inst[BIT_LOAD]                    = fields.load;
  end
endmodule

// File: rtl/ws_inst_sequencer.sv
// ws_inst_sequencer: generates the core instruction stream for one full
// weight-stationary convolution pass over all LEN_KIJ kernel positions.
// Per kij: load COL weight rows into L0, push them into the PEs, drain,
// load LEN_NIJ activation rows, execute, drain, then write back LEN_NIJ psum
// rows paced by ofifo_valid.
// Ports: clk, reset (async, active-low), bus (ws_inst_sequencer_if.master:
// start, ofifo_valid in; busy, done, kij_idx, inst out).
// Optional feature macro WS_SEQ_ACC_EN: in-place psum accumulation (every kij
// writes psum rows from address 0, with acc set for kij > 0).
module ws_inst_sequencer
  import ws_seq_pkg::*;
#(
  parameter int COL       = 8,
  parameter int LEN_NIJ   = 36,
  parameter int LEN_KIJ   = 9,
  parameter int DRAIN_CYC = 10,
  parameter int W_BASE    = 1024
) (
  input logic                 clk,
  input logic                 reset,
  ws_inst_sequencer_if.master bus
);
  localparam logic [CNT_W-1:0]   WL0_LAST = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0]   WPE_LAST = CNT_W'(2 * COL);
  localparam logic [CNT_W-1:0]   DRN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]   AL0_LAST = CNT_W'(LEN_NIJ - 1);
  localparam logic [CNT_W-1:0]   EXE_LAST = CNT_W'(LEN_NIJ);
  localparam logic [CNT_W-1:0]   ORD_LAST = CNT_W'(LEN_NIJ - 1);
  localparam logic [3:0]         KIJ_LAST = 4'(LEN_KIJ - 1);
  localparam logic [ADDR_BW-1:0] W_BASE_A  = ADDR_BW'(W_BASE);
  localparam logic [ADDR_BW-1:0] COL_A     = ADDR_BW'(COL);
  localparam logic [ADDR_BW-1:0] LEN_NIJ_A = ADDR_BW'(LEN_NIJ);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         kij_q, kij_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  inst_fields_t       fields;
  logic [ADDR_BW-1:0] kij_a, cnt_a;

  assign kij_a = ADDR_BW'(kij_q);
  assign cnt_a = ADDR_BW'(cnt_q);

  // Next state, counter and status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    kij_d   = kij_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = WL0;
        busy_d  = 1'b1;
      end
      WL0: if (cnt_q == WL0_LAST) state_d = WPE;
      WPE: if (cnt_q == WPE_LAST) state_d = WDR;
      WDR: if (cnt_q == DRN_LAST) state_d = AL0;
      AL0: if (cnt_q == AL0_LAST) state_d = EXE;
      EXE: if (cnt_q == EXE_LAST) state_d = EDR;
      EDR: if (cnt_q == DRN_LAST) state_d = ORD;
      ORD: begin
        // Only consumed psum rows advance the counter; stall otherwise.
        if (!bus.ofifo_valid)        cnt_d   = cnt_q;
        else if (cnt_q == ORD_LAST)  state_d = NXT;
      end
      NXT: begin
        if (kij_q == KIJ_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;  // busy drops as done rises
        end else begin
          kij_d   = kij_q + 4'd1;
          state_d = WL0;
        end
      end
      DONE: begin
        state_d = IDLE;
        kij_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    done_d = (state_d == DONE);
  end

  // Instruction fields for the current state; registered one cycle later.
  always_comb begin
    fields = INST_FIELDS_DEFAULT;
    case (state_q)
      WL0: begin
        fields.cen_xmem = 1'b0;
        fields.a_xmem   = W_BASE_A + kij_a * COL_A + cnt_a;
        fields.l0_wr    = 1'b1;
      end
      WPE: begin
        fields.l0_rd = 1'b1;
        fields.load  = 1'b1;
      end
      AL0: begin
        fields.cen_xmem = 1'b0;
        fields.a_xmem   = cnt_a;
        fields.l0_wr    = 1'b1;
      end
      EXE: begin
        fields.l0_rd   = 1'b1;
        fields.execute = 1'b1;
      end
      ORD: begin
`ifdef WS_SEQ_ACC_EN
        fields.acc = (kij_q != 4'd0);
`endif
        if (bus.ofifo_valid) begin
          fields.ofifo_rd = 1'b1;
          fields.cen_pmem = 1'b0;
          fields.wen_pmem = 1'b0;
`ifdef WS_SEQ_ACC_EN
          fields.a_pmem   = cnt_a;
`else
          fields.a_pmem   = kij_a * LEN_NIJ_A + cnt_a;
`endif
        end
      end
      default: ;
    endcase
  end

  ws_inst_pack u_pack (
    .fields (fields),
    .inst   (inst_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= INST_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.kij_idx = kij_q;
  assign bus.inst    = inst_q;

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// Bench for ws_inst_sequencer: directed steps with a scoreboard of expected
// xmem read addresses and psum write addresses, plus a small core model that
// tracks L0 occupancy and instruction-protocol rules.
module tb_ws_inst_sequencer;
  localparam int COL = 8, LEN_NIJ = 36, LEN_KIJ = 9, W_BASE = 1024;
  // Bit map of the instruction word, written out independently here.
  localparam int B_MODE = 34, B_ACC = 33, B_CENP = 32, B_WENP = 31, B_AP = 20;
  localparam int B_CENX = 19, B_WENX = 18, B_AX = 7, B_ORD = 6, B_IWR = 5;
  localparam int B_IRD = 4, B_L0RD = 3, B_L0WR = 2, B_EXE = 1;
  localparam logic [34:0] EXP_DEFAULT = 35'h1_800C_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ws_inst_sequencer_if bus();

  ws_inst_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int xq[$], pq[$];
  int busy_cnt, done_cnt, occ, valid_exec, exec_cyc, proto_err, wen_err;
  int cyc, k3_first, k3_last, k3_rd, e;
  bit mon_en = 1'b0;
  logic [34:0] iw;

  function automatic void chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  // Core model / scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      iw = bus.inst;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (!iw[B_CENX]) begin
        if (!iw[B_L0WR]) proto_err++;
        if (xq.size() == 0) chk("xmem_unexpected_read", 1, 0);
        else begin
          e = xq.pop_front();
          chk("A_xmem", iw[B_AX +: 11], e);
        end
      end else if (iw[B_L0WR]) proto_err++;
      if (!iw[B_WENX]) wen_err++;
      if (iw[B_MODE] | iw[B_IWR] | iw[B_IRD]) proto_err++;
      if ((iw[B_CENP] != iw[B_WENP]) || (iw[B_ORD] == iw[B_CENP])) proto_err++;
      if (!iw[B_CENP]) begin
        if (pq.size() == 0) chk("pmem_unexpected_write", 1, 0);
        else begin
          e = pq.pop_front();
          chk("A_pmem", iw[B_AP +: 11], e & 16'hFFFF);
          chk("acc", iw[B_ACC], e >> 16);
        end
      end
      if (iw[B_EXE]) exec_cyc++;
      if (iw[B_L0WR]) occ++;
      else if (iw[B_L0RD] && occ > 0) begin
        occ--;
        if (iw[B_EXE]) valid_exec++;
      end
      if (iw[B_ORD] && bus.kij_idx == 4'd3) begin
        if (k3_rd == 0) k3_first = cyc;
        k3_last = cyc;
        k3_rd++;
      end
    end
  end

  task automatic push_pass();
    xq.delete();
    pq.delete();
    for (int k = 0; k < LEN_KIJ; k++) begin
      for (int i = 0; i < COL; i++) xq.push_back((W_BASE + k * COL + i) % 2048);
      for (int j = 0; j < LEN_NIJ; j++) xq.push_back(j);
      for (int j = 0; j < LEN_NIJ; j++) begin
`ifdef WS_SEQ_ACC_EN
        pq.push_back(j | ((k > 0) ? 65536 : 0));
`else
        pq.push_back(k * LEN_NIJ + j);
`endif
      end
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; occ = 0; valid_exec = 0; exec_cyc = 0;
    proto_err = 0; wen_err = 0; cyc = 0; k3_first = 0; k3_last = 0; k3_rd = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic run_pass(input bit bp, input bit ign, input int exp_busy);
    bit ok;
    push_pass();
    clear_stats();
    pulse_start();
    if (ign) begin
      repeat (48) @(negedge clk);  // lands inside AL0 of kij 0
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk("kij_after_ignored_start", bus.kij_idx, 0);
      chk("busy_after_ignored_start", bus.busy, 1);
    end
    if (bp) begin
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        if (k3_rd > 0) begin ok = 1'b1; break; end
      end
      chk("reached_kij3_ord", ok, 1);
      repeat (3) @(negedge clk);
      bus.ofifo_valid = 1'b0;
      repeat (5) @(negedge clk);
      bus.ofifo_valid = 1'b1;
    end
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
    if (ign) begin  // start during DONE must be ignored
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end
    repeat (20) @(negedge clk);
    $display("pass bp=%0d ign=%0d busy_cycles=%0d done_pulses=%0d", bp, ign, busy_cnt, done_cnt);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("done_pulses", done_cnt, 1);
    chk("xq_left", xq.size(), 0);
    chk("pq_left", pq.size(), 0);
    chk("valid_exec", valid_exec, LEN_KIJ * LEN_NIJ);
    chk("exec_cycles", exec_cyc, LEN_KIJ * (LEN_NIJ + 1));
    chk("proto_err", proto_err, 0);
    chk("wen_xmem_writes", wen_err, 0);
    chk("busy_idle", bus.busy, 0);
    chk("kij_idle", bus.kij_idx, 0);
    chk("inst_idle", bus.inst, EXP_DEFAULT);
    if (bp) begin
      chk("k3_ofifo_rd_count", k3_rd, LEN_NIJ);
      chk("k3_ofifo_rd_span", k3_last - k3_first + 1, LEN_NIJ + 5);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inst", bus.inst, EXP_DEFAULT);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_kij", bus.kij_idx, 0);
    reset = 1'b1;
    mon_en = 1'b1;

    run_pass(1'b0, 1'b0, 1395);
    run_pass(1'b1, 1'b1, 1400);

    // Reset in the middle of kij 1 EXE abandons the pass.
    push_pass();
    clear_stats();
    pulse_start();
    repeat (240) @(negedge clk);
    chk("pre_reset_kij", bus.kij_idx, 1);
    reset = 1'b0;
    #1;
    $display("mid-pass reset inst=%h busy=%0d kij=%0d", bus.inst, bus.busy, bus.kij_idx);
    chk("mid_rst_inst", bus.inst, EXP_DEFAULT);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_kij", bus.kij_idx, 0);
    chk("mid_rst_done", bus.done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done_pulse", done_cnt, 0);
    chk("mid_rst_stays_idle", bus.busy, 0);

    run_pass(1'b0, 1'b0, 1395);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
